// File: rtl/tvla_pkg.sv
// Shared constants for the TVLA acquisition sequencer: FSM encodings, LFSR
// taps and seed, trace class codes and the LFSR next-state function.
package tvla_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GEN     = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_FIN     = 3'd5;

    localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

    localparam logic CLASS_FIXED  = 1'b0;
    localparam logic CLASS_RANDOM = 1'b1;

    // Right-shifting Galois step: the bit shifted out selects the tap mask.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/tvla_lfsr32.sv
// 32-bit Galois LFSR used as the random-plaintext source. A zero seed would
// lock the register at zero, so it is replaced by the default seed on load.
module tvla_lfsr32
    import tvla_pkg::*;
(
    input  logic        CLK,
    input  logic        R,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            state_q <= (seed == 32'h0) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/tvla_sequencer.sv
// Fixed-vs-random TVLA acquisition controller: per trace it picks a class,
// builds the plaintext, drives the cipher core and emits a tagged record.
module tvla_sequencer
    import tvla_pkg::*;
#(
    parameter int DW      = 128,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          CLK,
    input  logic          R,
    input  logic          start,
    input  logic [CW-1:0] n_traces,
    input  logic [DW-1:0] fixed_pt,
    input  logic [31:0]   seed,
    output logic          core_load,
    output logic [DW-1:0] core_pt,
    input  logic          core_done,
    input  logic [DW-1:0] core_ct,
    output logic          trig,
    output logic          trace_valid,
    output logic          trace_class,
    output logic [CW-1:0] trace_idx,
    output logic [DW-1:0] trace_ct,
    output logic          busy,
    output logic          done,
    output logic          timeout_err
);

    localparam int GEN_CYCLES = DW / 32;
    localparam int GW         = $clog2(GEN_CYCLES + 1);
    localparam int TW         = $clog2(TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic [GW-1:0] gen_q, gen_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] ntr_q, ntr_d;
    logic [DW-1:0] fpt_q, fpt_d;
    logic [DW-1:0] rnd_q, rnd_d;
    logic [DW-1:0] pt_q, pt_d;
    logic [DW-1:0] ct_q, ct_d;
    logic          class_q, class_d;
    logic          terr_q, terr_d;

    logic          lfsr_load;
    logic          lfsr_step;
    logic [31:0]   lfsr_state;

    tvla_lfsr32 u_lfsr (
        .CLK   (CLK),
        .R     (R),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    always_comb begin
        state_d   = state_q;
        gen_d     = gen_q;
        tmo_d     = tmo_q;
        idx_d     = idx_q;
        ntr_d     = ntr_q;
        fpt_d     = fpt_q;
        rnd_d     = rnd_q;
        pt_d      = pt_q;
        ct_d      = ct_q;
        class_d   = class_q;
        terr_d    = terr_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ntr_d     = n_traces;
                    fpt_d     = fixed_pt;
                    idx_d     = '0;
                    gen_d     = '0;
                    terr_d    = 1'b0;
                    lfsr_load = 1'b1;
                    state_d   = (n_traces == '0) ? ST_FIN : ST_GEN;
                end
            end
            ST_GEN: begin
                // Class comes from the pre-step LFSR so both classes consume
                // the same number of steps per trace.
                lfsr_step = 1'b1;
                rnd_d     = (rnd_q << 32) | DW'(lfsr_next(lfsr_state));
                if (gen_q == '0) begin
                    class_d = lfsr_state[0];
                end
                if (gen_q == GW'(GEN_CYCLES - 1)) begin
                    gen_d   = '0;
                    pt_d    = (class_d == CLASS_RANDOM) ? rnd_d : fpt_q;
                    state_d = ST_LOAD;
                end else begin
                    gen_d = gen_q + 1'b1;
                end
            end
            ST_LOAD: begin
                tmo_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (core_done) begin
                    ct_d    = core_ct;
                    state_d = ST_CAPTURE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (idx_q == ntr_q - 1'b1) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_GEN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= ST_IDLE;
            gen_q   <= '0;
            tmo_q   <= '0;
            idx_q   <= '0;
            ntr_q   <= '0;
            fpt_q   <= '0;
            rnd_q   <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            class_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            tmo_q   <= tmo_d;
            idx_q   <= idx_d;
            ntr_q   <= ntr_d;
            fpt_q   <= fpt_d;
            rnd_q   <= rnd_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            class_q <= class_d;
            terr_q  <= terr_d;
        end
    end

    // The power window spans the load strobe and every cycle spent waiting.
    assign core_load   = (state_q == ST_LOAD);
    assign core_pt     = pt_q;
    assign trig        = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign trace_valid = (state_q == ST_CAPTURE);
    assign trace_class = class_q;
    assign trace_idx   = idx_q;
    assign trace_ct    = ct_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign timeout_err = terr_q;

endmodule

// File: doc/tvla_sequencer.md
# tvla_sequencer

Acquisition controller for simulation-based TVLA of the gate-level cipher netlist. It sequences a fixed-vs-random test: for each trace it picks the class, builds the plaintext, loads the cipher core and waits for its completion. It then emits a tagged trace record and a trigger. It sits between the testbench/host and the mapped AES-128 core and paces the core one trace at a time.

## Interface
- DW, 128: plaintext/ciphertext width; multiple of 32.
- CW, 16: trace counter width.
- TIMEOUT, 1024: maximum RUN cycles before abort.
- CLK  in  1  clock, rising edge.
- R  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a campaign when idle.
- n_traces  in  CW  number of traces; sampled on accepted start.
- fixed_pt  in  DW  fixed-class plaintext; sampled on accepted start.
- seed  in  32  LFSR seed; sampled on accepted start; 0 is replaced by 32'h1.
- core_load  out  1  one-cycle load strobe to the cipher core.
- core_pt  out  DW  plaintext to the core; held stable from LOAD until the next GEN.
- core_done  in  1  core completion pulse.
- core_ct  in  DW  core ciphertext; valid with core_done.
- trig  out  1  high from LOAD through the cycle core_done is seen (power-window marker).
- trace_valid  out  1  one-cycle trace record strobe.
- trace_class  out  1  0 = fixed, 1 = random; valid with trace_valid.
- trace_idx  out  CW  trace number from 0; valid with trace_valid.
- trace_ct  out  DW  captured ciphertext.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle campaign-end pulse.
- timeout_err  out  1  sticky; cleared by the next accepted start.

## Operation
- Register states: IDLE, GEN, LOAD, RUN, CAPTURE, FIN.
- IDLE: start=1 latches the inputs, clears idx and timeout_err, and loads the LFSR. If n_traces==0 → FIN, else → GEN.
- start is ignored in any state other than IDLE.
- LFSR: 32-bit Galois, taps 32'h80200003, one shift per step.
- GEN: lasts DW/32 cycles.
  - On the first GEN cycle, the class is LFSR bit 0, taken before stepping.
  - Each cycle steps the LFSR and shifts the new state into a DW-bit random register, first word landing in the MSBs.
  - The LFSR steps identically for both classes, so the sequence is class-independent.
- LOAD: core_load=1 and trig rises. core_pt is fixed_pt for class 0, otherwise the random register. → RUN.
- RUN: waits for core_done. A cycle counter reset in LOAD counts RUN cycles.
  - core_done → CAPTURE, latching core_ct.
  - Counter reaching TIMEOUT with no core_done → timeout_err=1, → FIN; no trace record is emitted.
- CAPTURE: trace_valid=1 with class, idx and ct. If idx==n_traces-1 → FIN, else idx+1 → GEN.
- FIN: done=1 for one cycle → IDLE.
- core_done outside RUN is ignored.

## Timing
- Reset (R low, asynchronous): state IDLE, every output 0, LFSR 32'h1, counters 0.
- Reset mid-campaign aborts immediately. No done pulse is issued.
- With accepted start at cycle 0:
  - GEN occupies cycles 1..DW/32 (1..4 for DW=128).
  - core_load is high at cycle DW/32+1.
  - If core_done arrives k cycles after LOAD (k≥1), trace_valid is at LOAD+k+1.
  - The next GEN begins at LOAD+k+2.
  - Per-trace period = DW/32 + k + 2 cycles.
- done follows the last CAPTURE by one cycle. busy falls in the cycle after done.
- trig falls in the cycle after core_done, or in FIN on timeout.

## Structure
- Package tvla_pkg holds:
  - the state enum;
  - the LFSR tap constant 32'h80200003;
  - the default seed 32'h1;
  - the CLASS_FIXED/CLASS_RANDOM constants.
- One sub-module, tvla_lfsr32 (CLK, R, load, seed, step, state). It owns the zero-seed substitution.
- Everything else lives in tvla_sequencer.

## Test plan
- Reset values: R low mid-RUN with trace 2 of 5 → all outputs 0, state IDLE, no done pulse. After R high, a new start runs trace_idx from 0.
- Basic campaign: n_traces=3, DW=128, core_done 5 cycles after each core_load → core_load at cycles 5, 16, 27; trace_valid at 11, 22, 33 with idx 0, 1, 2; done at 34; busy low at 35.
- Class and plaintext:
  - fixed_pt=128'h0123…cdef with a seed giving class 0 → core_pt equals fixed_pt.
  - A class-1 trace → core_pt equals the concatenation of 4 successive reference-model LFSR states.
  - Same seed rerun → identical class and plaintext sequence.
- Zero/edge values:
  - n_traces=0 → done at cycle 1, no core_load.
  - seed=0 → same sequence as seed=1.
  - start asserted while busy → no effect.
- Timeout: TIMEOUT=8, core_done never asserted → timeout_err=1 and done 9 cycles after LOAD, no trace_valid. Next start clears timeout_err.
- Stray completion: core_done pulsed during GEN → ignored; the trace completes only on the RUN-state core_done.
